// File: rtl/rtc_calendar_core_if.sv
`default_nettype none
// ============================================================================
// Module   : rtc_calendar_core_if
// Brief    : Control, set-value and time-output bundle of the RTC core.
// Revision : 1.0 - initial release
// ============================================================================
interface rtc_calendar_core_if;
    logic        run;
    logic        load;
    logic [15:0] set_year;
    logic [7:0]  set_month;
    logic [7:0]  set_day;
    logic [7:0]  set_hour;
    logic [7:0]  set_minute;
    logic [7:0]  set_sec;
    logic [3:0]  set_week;
    logic [15:0] year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  sec;
    logic [3:0]  week;
    logic        sec_pulse;
    logic        load_ack;
    logic        load_err;

    modport master (
        output run, load, set_year, set_month, set_day, set_hour, set_minute,
               set_sec, set_week,
        input  year, month, day, hour, minute, sec, week,
               sec_pulse, load_ack, load_err
    );

    modport slave (
        input  run, load, set_year, set_month, set_day, set_hour, set_minute,
               set_sec, set_week,
        output year, month, day, hour, minute, sec, week,
               sec_pulse, load_ack, load_err
    );
endinterface
`default_nettype wire

// File: rtl/rtc_calendar_core.sv
`default_nettype none
// ============================================================================
// Module   : rtc_calendar_core
// Brief    : BCD Gregorian calendar/clock with validated load and prescaler.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_calendar_core #(
    parameter int DIV = 1000,
    parameter int CW  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rtc_calendar_core_if.slave cal
);

    function automatic logic [7:0] inc8(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc8w(input logic [7:0] v);
        return (v == 8'h99) ? 8'h00 : inc8(v);
    endfunction

    // Two BCD digits T,U: (10T+U) mod 4 == (2T+U) mod 4.
    function automatic logic div4(input logic [7:0] b);
        if (b[4])
            return (b[3:0] == 4'd2) || (b[3:0] == 4'd6);
        else
            return (b[3:0] == 4'd0) || (b[3:0] == 4'd4) || (b[3:0] == 4'd8);
    endfunction

    function automatic logic leap(input logic [15:0] y);
        return (y[7:0] == 8'h00) ? div4(y[15:8]) : div4(y[7:0]);
    endfunction

    function automatic logic [7:0] dim(input logic [7:0] m, input logic lp);
        case (m)
            8'h02:                      return lp ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    logic [CW-1:0] pre_q, pre_d;
    logic [15:0]   year_q, year_d;
    logic [7:0]    month_q, month_d, day_q, day_d;
    logic [7:0]    hour_q, hour_d, minute_q, minute_d, sec_q, sec_d;
    logic [3:0]    week_q, week_d;
    logic          pulse_q, pulse_d, ack_q, ack_d, err_q, err_d;

    logic          nib_ok, set_valid, load_ok, tick;
    logic [7:0]    dim_cur, dim_set;

    assign dim_cur = dim(month_q, leap(year_q));
    assign dim_set = dim(cal.set_month, leap(cal.set_year));

    assign nib_ok = (cal.set_year[15:12] <= 4'd9) && (cal.set_year[11:8] <= 4'd9) &&
                    (cal.set_year[7:4]   <= 4'd9) && (cal.set_year[3:0]  <= 4'd9) &&
                    (cal.set_month[7:4]  <= 4'd9) && (cal.set_month[3:0] <= 4'd9) &&
                    (cal.set_day[7:4]    <= 4'd9) && (cal.set_day[3:0]   <= 4'd9) &&
                    (cal.set_hour[7:4]   <= 4'd9) && (cal.set_hour[3:0]  <= 4'd9) &&
                    (cal.set_minute[7:4] <= 4'd9) && (cal.set_minute[3:0] <= 4'd9) &&
                    (cal.set_sec[7:4]    <= 4'd9) && (cal.set_sec[3:0]   <= 4'd9);

    // Once every nibble is a decimal digit, byte compares order like numbers.
    assign set_valid = nib_ok &&
                       (cal.set_month >= 8'h01) && (cal.set_month <= 8'h12) &&
                       (cal.set_day >= 8'h01) && (cal.set_day <= dim_set) &&
                       (cal.set_hour <= 8'h23) && (cal.set_minute <= 8'h59) &&
                       (cal.set_sec <= 8'h59) &&
                       (cal.set_week >= 4'd1) && (cal.set_week <= 4'd7);

    assign load_ok = cal.load && set_valid;
    assign tick    = cal.run && (pre_q == CW'(DIV - 1));

    always_comb begin
        pre_d    = pre_q;
        year_d   = year_q;
        month_d  = month_q;
        day_d    = day_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        sec_d    = sec_q;
        week_d   = week_q;
        pulse_d  = 1'b0;
        ack_d    = load_ok;
        err_d    = cal.load && !set_valid;

        if (!cal.run || tick)
            pre_d = '0;
        else
            pre_d = pre_q + CW'(1);

        if (load_ok) begin
            pre_d    = '0;
            year_d   = cal.set_year;
            month_d  = cal.set_month;
            day_d    = cal.set_day;
            hour_d   = cal.set_hour;
            minute_d = cal.set_minute;
            sec_d    = cal.set_sec;
            week_d   = cal.set_week;
        end else if (tick) begin
            pulse_d = 1'b1;
            sec_d   = (sec_q == 8'h59) ? 8'h00 : inc8(sec_q);
            if (sec_q == 8'h59) begin
                minute_d = (minute_q == 8'h59) ? 8'h00 : inc8(minute_q);
                if (minute_q == 8'h59) begin
                    hour_d = (hour_q == 8'h23) ? 8'h00 : inc8(hour_q);
                    if (hour_q == 8'h23) begin
                        week_d = (week_q == 4'd7) ? 4'd1 : week_q + 4'd1;
                        if (day_q == dim_cur) begin
                            day_d = 8'h01;
                            if (month_q == 8'h12) begin
                                month_d = 8'h01;
                                year_d[7:0]  = inc8w(year_q[7:0]);
                                year_d[15:8] = (year_q[7:0] == 8'h99) ?
                                               inc8w(year_q[15:8]) : year_q[15:8];
                            end else begin
                                month_d = inc8(month_q);
                            end
                        end else begin
                            day_d = inc8(day_q);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            year_q   <= 16'h2000;
            month_q  <= 8'h01;
            day_q    <= 8'h01;
            hour_q   <= 8'h00;
            minute_q <= 8'h00;
            sec_q    <= 8'h00;
            week_q   <= 4'd6;
            pulse_q  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            year_q   <= year_d;
            month_q  <= month_d;
            day_q    <= day_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            sec_q    <= sec_d;
            week_q   <= week_d;
            pulse_q  <= pulse_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign cal.year      = year_q;
    assign cal.month     = month_q;
    assign cal.day       = day_q;
    assign cal.hour      = hour_q;
    assign cal.minute    = minute_q;
    assign cal.sec       = sec_q;
    assign cal.week      = week_q;
    assign cal.sec_pulse = pulse_q;
    assign cal.load_ack  = ack_q;
    assign cal.load_err  = err_q;

endmodule
`default_nettype wire

// File: doc/rtc_calendar_core.md
Name: rtc_calendar_core

Overview:
- Timekeeping engine that consumes the date/time words produced by the button-driven time-setting logic and keeps them running.
- Accepts a validated load of year, month, day, hour, minute, second and weekday, then advances in real time with full Gregorian calendar handling.
- Its outputs feed the display-string and scan path in the same BCD format the setter produces.

Parameters:
- DIV, 1000, number of clk cycles per second (minimum 2).
- CW, 16, prescaler counter width; must satisfy 2^CW >= DIV.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  1 = time advances; 0 = frozen, prescaler held at 0.
- load  input  1  single-cycle request to load the set_* values.
- set_year  input  16  4-digit BCD year, 0000-9999.
- set_month  input  8  2-digit BCD, 01-12.
- set_day  input  8  2-digit BCD, 01 up to days-in-month.
- set_hour  input  8  2-digit BCD, 00-23.
- set_minute  input  8  2-digit BCD, 00-59.
- set_sec  input  8  2-digit BCD, 00-59.
- set_week  input  4  binary 1-7; 1 = Monday, 7 = Sunday.
- year  output  16  current year, BCD.
- month  output  8  current month, BCD.
- day  output  8  current day, BCD.
- hour  output  8  current hour, BCD.
- minute  output  8  current minute, BCD.
- sec  output  8  current second, BCD.
- week  output  4  current weekday, 1-7.
- sec_pulse  output  1  one-cycle pulse in the cycle the time fields change because of a tick.
- load_ack  output  1  one-cycle pulse: load was accepted.
- load_err  output  1  one-cycle pulse: load was rejected.

Behaviour:
- All outputs are registered.
- Reset (async, any time): 2000-01-01 00:00:00, week = 6 (Saturday). Prescaler = 0. sec_pulse, load_ack and load_err are all 0.
- Prescaler:
  - When run = 1, it counts 0..DIV-1.
  - A tick is the cycle in which prescaler = DIV-1; prescaler wraps to 0 on the next edge.
  - When run = 0, the prescaler is held at 0 and no tick occurs.
- Tick handling:
  - On the edge that closes a tick cycle, time advances one second and sec_pulse = 1 for the following cycle.
  - The first tick after reset or after run rises comes exactly DIV cycles later.
- Carry chain, all in BCD:
  - Second 59 -> 00 carries into minute.
  - Minute 59 -> 00 carries into hour.
  - Hour 23 -> 00 carries into day and week.
  - Day wraps to 01 after days-in-month and carries into month.
  - Month 12 -> 01 carries into year.
  - Year 9999 -> 0000.
  - Week 7 -> 1 on every day carry.
  - Each BCD digit 9 -> 0 carries into the next digit; no binary intermediate may appear on any output.
- Days in month:
  - 31 for months 01, 03, 05, 07, 08, 10, 12.
  - 30 for months 04, 06, 09, 11.
  - February is 29 in leap years, otherwise 28.
- Leap year rule (Gregorian), computed directly from BCD digits:
  - Century years (low two digits = 00): leap if the high two digits are divisible by 4.
  - All other years: leap if the low two digits are divisible by 4.
  - Year 0000 counts as leap.
- Load validation, combinational, in the cycle load = 1. The load is accepted only if:
  - every BCD nibble is 0-9, and every field is in range;
  - day <= days-in-month of set_month and set_year;
  - set_week is 1-7.
- Accepted load:
  - All fields take the set_* values on the next edge.
  - Prescaler is cleared to 0.
  - load_ack = 1 for one cycle.
- Rejected load: all fields and the prescaler are unchanged; load_err = 1 for one cycle.
- Load and tick in the same cycle:
  - An accepted load wins; the tick is discarded and sec_pulse stays 0.
  - On a rejected load the tick proceeds normally.
- load while run = 0 is legal; the loaded time is held frozen.
- load held high for N cycles is treated as N separate loads; each cycle is validated and acknowledged on its own.
- Latency: load -> outputs valid 1 cycle later. Tick cycle -> outputs updated 1 cycle later.

Test Plan:
- Reset and free run, DIV = 4: assert rst mid-count -> outputs 2000-01-01 00:00:00, week 6. Release rst with run = 1 -> first sec_pulse after exactly 4 cycles, sec = 01.
- Full rollover: load 9999-12-31 23:59:59, week 5, then one tick -> 0000-01-01 00:00:00, week 6, single sec_pulse.
- Leap years: load Feb-28 23:59:59 for 2024, 2023, 2100 and 2000, one tick each -> 02-29, 03-01, 03-01, 02-29 respectively. Tick again from 2024-02-29 23:59:59 -> 03-01.
- Invalid loads, each must give load_err, no load_ack and unchanged outputs:
  - 2023-02-29;
  - month 13;
  - sec 0x5A;
  - week 0.
- Load/tick collision: assert a valid load exactly in the tick cycle -> loaded values appear, no sec_pulse, next sec_pulse exactly DIV cycles later.
- Freeze: run = 0 for 3*DIV cycles -> no sec_pulse and outputs constant. run = 1 -> ticks resume after DIV cycles.
